// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared MIDI definitions for the message parser:
//   - status byte constants for the message types the parser distinguishes
//   - midi_data_len(): number of data bytes that follow a status byte
//   - fetch_state_t: states of the FIFO fetch sequencer
// -----------------------------------------------------------------------------
package midi_pkg;

    localparam logic [7:0] NOTE_OFF     = 8'h80;
    localparam logic [7:0] NOTE_ON      = 8'h90;
    localparam logic [7:0] POLY_AT      = 8'hA0;
    localparam logic [7:0] CC           = 8'hB0;
    localparam logic [7:0] PROG_CHG     = 8'hC0;
    localparam logic [7:0] CHAN_AT      = 8'hD0;
    localparam logic [7:0] PITCH_BEND   = 8'hE0;
    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] MTC_QFRAME   = 8'hF1;
    localparam logic [7:0] SONG_POS     = 8'hF2;
    localparam logic [7:0] SONG_SEL     = 8'hF3;
    localparam logic [7:0] UNDEF_F4     = 8'hF4;
    localparam logic [7:0] UNDEF_F5     = 8'hF5;
    localparam logic [7:0] TUNE_REQ     = 8'hF6;
    localparam logic [7:0] SYSEX_END    = 8'hF7;
    localparam logic [7:0] RT_FIRST     = 8'hF8;
    localparam logic [7:0] RT_ACT_SENSE = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_EMIT
    } fetch_state_t;

    // Data bytes carried by a message with this status byte. Only meaningful
    // for status bytes (bit 7 set); real-time and SysEx framing return 0.
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        if ((status[7:4] == PROG_CHG[7:4]) || (status[7:4] == CHAN_AT[7:4])) begin
            len = 2'd1;
        end else if (status[7] && (status < SYSEX_START)) begin
            len = 2'd2;
        end else begin
            case (status)
                MTC_QFRAME, SONG_SEL: len = 2'd1;
                SONG_POS:             len = 2'd2;
                default:              len = 2'd0;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// -----------------------------------------------------------------------------
// midi_msg_parser
// Drains the MIDI receive byte FIFO one byte at a time and assembles complete
// messages (running status, SysEx skipping, real-time passthrough).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   fifo_empty          FIFO empty flag
//   fifo_rd_data[7:0]   FIFO head byte (registered inside the FIFO)
//   fifo_rd             pop strobe, one cycle per consumed byte
//   msg_valid/msg_ready message handshake; outputs held stable while valid
//   msg_status[7:0]     status byte (explicit or running)
//   msg_data1/2[6:0]    data bytes, zero beyond msg_len
//   msg_len[1:0]        number of data bytes (0..2)
//   rt_valid, rt_byte   one-cycle real-time byte pulse (no back-pressure)
//   drop_cnt[7:0]       saturating count of discarded bytes/messages
// -----------------------------------------------------------------------------
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter bit         OMNI           = 1'b1,
    parameter logic [3:0] CHANNEL        = 4'd0,
    parameter bit         DROP_ACT_SENSE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       rt_valid,
    output logic [7:0] rt_byte,
    output logic [7:0] drop_cnt
);

    fetch_state_t r_state;

    logic       r_fifo_rd;
    logic       r_msg_valid;
    logic [7:0] r_msg_status;
    logic [6:0] r_msg_d1;
    logic [6:0] r_msg_d2;
    logic [1:0] r_msg_len;
    logic       r_rt_valid;
    logic [7:0] r_rt_byte;
    logic [7:0] r_drop_cnt;

    // Assembly state. r_active: a status is in force and data bytes are
    // accepted. r_keep: the status survives completion (running status).
    logic [7:0] r_cur_status;
    logic       r_active;
    logic       r_keep;
    logic [1:0] r_need;
    logic [1:0] r_cnt;
    logic [6:0] r_d1;
    logic       r_in_sysex;

    logic [7:0] w_byte;
    logic       w_partial;
    logic [7:0] w_cur_n;
    logic       w_active_n;
    logic       w_keep_n;
    logic [1:0] w_need_n;
    logic [1:0] w_cnt_n;
    logic [6:0] w_d1_n;
    logic       w_sysex_n;
    logic [1:0] w_drop_inc;
    logic       w_complete;
    logic       w_filtered;
    logic       w_emit;
    logic       w_rt_hit;
    logic [7:0] w_msg_status;
    logic [6:0] w_msg_d1;
    logic [6:0] w_msg_d2;
    logic [1:0] w_msg_len;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Classification of the byte at the FIFO head; only applied in CAPTURE.
    always_comb begin
        w_byte       = fifo_rd_data;
        w_partial    = r_active && (r_cnt != 2'd0);
        w_cur_n      = r_cur_status;
        w_active_n   = r_active;
        w_keep_n     = r_keep;
        w_need_n     = r_need;
        w_cnt_n      = r_cnt;
        w_d1_n       = r_d1;
        w_sysex_n    = r_in_sysex;
        w_drop_inc   = 2'd0;
        w_complete   = 1'b0;
        w_rt_hit     = 1'b0;
        w_msg_status = r_cur_status;
        w_msg_d1     = 7'd0;
        w_msg_d2     = 7'd0;
        w_msg_len    = 2'd0;

        if (w_byte >= RT_FIRST) begin
            // Real-time bytes interleave anywhere and leave assembly untouched.
            w_rt_hit = !(DROP_ACT_SENSE && (w_byte == RT_ACT_SENSE));
        end else if (w_byte[7]) begin
            // Any status byte abandons a half-received message and clears
            // running status unless it is itself a channel-voice status.
            w_drop_inc = {1'b0, w_partial};
            w_cnt_n    = 2'd0;
            w_sysex_n  = 1'b0;
            w_active_n = 1'b0;
            w_keep_n   = 1'b0;
            if (w_byte < SYSEX_START) begin
                w_cur_n    = w_byte;
                w_active_n = 1'b1;
                w_keep_n   = 1'b1;
                w_need_n   = midi_data_len(w_byte);
            end else begin
                case (w_byte)
                    SYSEX_START: w_sysex_n = 1'b1;
                    MTC_QFRAME, SONG_POS, SONG_SEL: begin
                        w_cur_n    = w_byte;
                        w_active_n = 1'b1;
                        w_need_n   = midi_data_len(w_byte);
                    end
                    TUNE_REQ: begin
                        w_complete   = 1'b1;
                        w_msg_status = w_byte;
                    end
                    UNDEF_F4, UNDEF_F5: w_drop_inc = w_drop_inc + 2'd1;
                    default: ;
                endcase
            end
        end else if (r_in_sysex) begin
            // SysEx payload is not forwarded.
        end else if (!r_active) begin
            w_drop_inc = 2'd1;
        end else if ((r_cnt == 2'd0) && (r_need == 2'd2)) begin
            w_d1_n  = w_byte[6:0];
            w_cnt_n = 2'd1;
        end else begin
            w_complete = 1'b1;
            w_msg_len  = r_need;
            if (r_need == 2'd1) begin
                w_msg_d1 = w_byte[6:0];
            end else begin
                w_msg_d1 = r_d1;
                w_msg_d2 = w_byte[6:0];
            end
            w_cnt_n = 2'd0;
            if (!r_keep) begin
                w_active_n = 1'b0;
            end
        end

        w_filtered = !OMNI && w_msg_status[7] && (w_msg_status[7:4] != 4'hF)
                     && (w_msg_status[3:0] != CHANNEL);
        w_emit     = w_complete && !w_filtered;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_fifo_rd    <= 1'b0;
            r_msg_valid  <= 1'b0;
            r_msg_status <= 8'd0;
            r_msg_d1     <= 7'd0;
            r_msg_d2     <= 7'd0;
            r_msg_len    <= 2'd0;
            r_rt_valid   <= 1'b0;
            r_rt_byte    <= 8'd0;
            r_drop_cnt   <= 8'd0;
            r_cur_status <= 8'd0;
            r_active     <= 1'b0;
            r_keep       <= 1'b0;
            r_need       <= 2'd0;
            r_cnt        <= 2'd0;
            r_d1         <= 7'd0;
            r_in_sysex   <= 1'b0;
        end else begin
            r_fifo_rd  <= 1'b0;
            r_rt_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // The pop strobe is registered so it lines up with CAPTURE.
                    if (fifo_empty) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state   <= ST_CAPTURE;
                        r_fifo_rd <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_cur_status <= w_cur_n;
                    r_active     <= w_active_n;
                    r_keep       <= w_keep_n;
                    r_need       <= w_need_n;
                    r_cnt        <= w_cnt_n;
                    r_d1         <= w_d1_n;
                    r_in_sysex   <= w_sysex_n;
                    r_drop_cnt   <= sat_add(r_drop_cnt, w_drop_inc);
                    if (w_rt_hit) begin
                        r_rt_valid <= 1'b1;
                        r_rt_byte  <= w_byte;
                    end
                    if (w_emit) begin
                        r_msg_valid  <= 1'b1;
                        r_msg_status <= w_msg_status;
                        r_msg_d1     <= w_msg_d1;
                        r_msg_d2     <= w_msg_d2;
                        r_msg_len    <= w_msg_len;
                        r_state      <= ST_EMIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (msg_ready) begin
                        r_msg_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rd    = r_fifo_rd;
    assign msg_valid  = r_msg_valid;
    assign msg_status = r_msg_status;
    assign msg_data1  = r_msg_d1;
    assign msg_data2  = r_msg_d2;
    assign msg_len    = r_msg_len;
    assign rt_valid   = r_rt_valid;
    assign rt_byte    = r_rt_byte;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_midi_msg_parser.sv
// -----------------------------------------------------------------------------
// tb_midi_msg_parser
// Two parser instances: [0] OMNI=1, [1] OMNI=0 listening on channel 2. Each
// has a small FIFO model fed from a byte array. A byte-level message model
// predicts messages, real-time pulses and the drop count.
// -----------------------------------------------------------------------------
module tb_midi_msg_parser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       f_empty    [2];
    logic [7:0] f_data     [2];
    logic       f_rd       [2];
    logic       msg_valid  [2];
    logic       msg_ready  [2];
    logic [7:0] msg_status [2];
    logic [6:0] msg_d1     [2];
    logic [6:0] msg_d2     [2];
    logic [1:0] msg_len    [2];
    logic       rt_valid   [2];
    logic [7:0] rt_byte    [2];
    logic [7:0] drop_cnt   [2];

    logic [7:0] stim_mem [2][1024];
    int wr_ptr [2] = '{0, 0};
    int rd_ptr [2] = '{0, 0};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        midi_msg_parser #(
            .OMNI          (g == 0),
            .CHANNEL       (4'd2),
            .DROP_ACT_SENSE(1'b1)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .fifo_empty  (f_empty[g]),
            .fifo_rd_data(f_data[g]),
            .fifo_rd     (f_rd[g]),
            .msg_valid   (msg_valid[g]),
            .msg_ready   (msg_ready[g]),
            .msg_status  (msg_status[g]),
            .msg_data1   (msg_d1[g]),
            .msg_data2   (msg_d2[g]),
            .msg_len     (msg_len[g]),
            .rt_valid    (rt_valid[g]),
            .rt_byte     (rt_byte[g]),
            .drop_cnt    (drop_cnt[g])
        );
        assign f_empty[g] = (rd_ptr[g] == wr_ptr[g]);
    end

    // FIFO model: head data is registered, so it follows the read pointer
    // one cycle late.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            f_data[g] <= stim_mem[g][rd_ptr[g]];
            if (f_rd[g] && (rd_ptr[g] != wr_ptr[g])) rd_ptr[g] <= rd_ptr[g] + 1;
        end
    end

    int total = 0;
    int bad   = 0;
    int rd_cnt  [2] = '{0, 0};
    int msg_cnt [2] = '{0, 0};
    int rt_cnt  [2] = '{0, 0};
    logic [31:0] last_msg [2];
    logic [7:0]  last_rt  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- message model ----------------
    logic [31:0] exp_msg0 [$];
    logic [31:0] exp_msg1 [$];
    logic [7:0]  exp_rt0  [$];
    logic [7:0]  exp_rt1  [$];
    int   m_st   [2];
    int   m_need [2];
    bit   m_keep [2];
    int   m_nd   [2];
    bit   m_sx   [2];
    int   m_drop [2];
    logic [6:0] m_first [2];

    function automatic logic [31:0] pack_msg(input logic [7:0] s, input logic [6:0] a,
                                             input logic [6:0] b, input logic [1:0] n);
        return {s, 1'b0, a, 1'b0, b, 6'd0, n};
    endfunction

    function automatic int msg_q_size(input int g);
        return (g == 0) ? exp_msg0.size() : exp_msg1.size();
    endfunction
    function automatic logic [31:0] msg_q_head(input int g);
        return (g == 0) ? exp_msg0[0] : exp_msg1[0];
    endfunction
    function automatic void msg_q_pop(input int g);
        if (g == 0) void'(exp_msg0.pop_front()); else void'(exp_msg1.pop_front());
    endfunction
    function automatic int rt_q_size(input int g);
        return (g == 0) ? exp_rt0.size() : exp_rt1.size();
    endfunction
    function automatic logic [7:0] rt_q_head(input int g);
        return (g == 0) ? exp_rt0[0] : exp_rt1[0];
    endfunction
    function automatic void rt_q_pop(input int g);
        if (g == 0) void'(exp_rt0.pop_front()); else void'(exp_rt1.pop_front());
    endfunction

    function automatic void model_reset();
        exp_msg0.delete(); exp_msg1.delete(); exp_rt0.delete(); exp_rt1.delete();
        for (int g = 0; g < 2; g++) begin
            m_st[g] = -1; m_need[g] = 0; m_keep[g] = 0; m_nd[g] = 0;
            m_sx[g] = 0; m_drop[g] = 0; m_first[g] = 7'd0;
        end
    endfunction

    function automatic void bump(input int g);
        if (m_drop[g] < 255) m_drop[g]++;
    endfunction

    function automatic void emit(input int g, input logic [7:0] s, input logic [6:0] a,
                                 input logic [6:0] b, input logic [1:0] n);
        // Instance 1 only hears channel 2 for channel-voice messages.
        if (g == 1 && s < 8'hF0 && s[3:0] != 4'd2) return;
        if (g == 0) exp_msg0.push_back(pack_msg(s, a, b, n));
        else        exp_msg1.push_back(pack_msg(s, a, b, n));
    endfunction

    function automatic void model_byte(input int g, input logic [7:0] b);
        logic [7:0] st;
        if (b >= 8'hF8) begin
            if (b != 8'hFE) begin
                if (g == 0) exp_rt0.push_back(b); else exp_rt1.push_back(b);
            end
        end else if (b[7]) begin
            if (m_st[g] >= 0 && m_nd[g] > 0) bump(g);
            m_nd[g] = 0; m_sx[g] = 0; m_st[g] = -1; m_keep[g] = 0;
            if (b < 8'hF0) begin
                m_st[g] = int'(b); m_keep[g] = 1;
                m_need[g] = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
            end else if (b == 8'hF0) m_sx[g] = 1;
            else if (b == 8'hF1 || b == 8'hF3) begin m_st[g] = int'(b); m_need[g] = 1; end
            else if (b == 8'hF2) begin m_st[g] = int'(b); m_need[g] = 2; end
            else if (b == 8'hF6) emit(g, 8'hF6, 7'd0, 7'd0, 2'd0);
            else if (b == 8'hF4 || b == 8'hF5) bump(g);
        end else if (m_sx[g]) begin
        end else if (m_st[g] < 0) begin
            bump(g);
        end else begin
            m_nd[g]++;
            st = m_st[g][7:0];
            if (m_nd[g] == m_need[g]) begin
                if (m_need[g] == 1) emit(g, st, b[6:0], 7'd0, 2'd1);
                else                emit(g, st, m_first[g], b[6:0], 2'd2);
                m_nd[g] = 0;
                if (!m_keep[g]) m_st[g] = -1;
            end else begin
                m_first[g] = b[6:0];
            end
        end
    endfunction

    // ---------------- compare process ----------------
    task automatic compare_loop();
        logic [31:0] act_msg;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                for (int g = 0; g < 2; g++) begin
                    if (f_rd[g]) rd_cnt[g]++;
                    if (msg_valid[g]) begin
                        act_msg = pack_msg(msg_status[g], msg_d1[g], msg_d2[g], msg_len[g]);
                        chk("no_pop_during_emit", {31'd0, f_rd[g]}, 32'd0);
                        chk("msg_expected", (msg_q_size(g) > 0) ? 32'd1 : 32'd0, 32'd1);
                        if (msg_q_size(g) > 0) chk("msg_fields", act_msg, msg_q_head(g));
                        if (msg_ready[g]) begin
                            if (msg_q_size(g) > 0) msg_q_pop(g);
                            last_msg[g] = act_msg;
                            msg_cnt[g]++;
                        end
                    end
                    if (rt_valid[g]) begin
                        chk("rt_expected", (rt_q_size(g) > 0) ? 32'd1 : 32'd0, 32'd1);
                        if (rt_q_size(g) > 0) begin
                            chk("rt_byte", {24'd0, rt_byte[g]}, {24'd0, rt_q_head(g)});
                            rt_q_pop(g);
                        end
                        last_rt[g] = rt_byte[g];
                        rt_cnt[g]++;
                    end
                end
            end
        end
    endtask

    task automatic push(input int g, input logic [7:0] b);
        @(posedge clk); #2;
        stim_mem[g][wr_ptr[g]] = b;
        wr_ptr[g] = wr_ptr[g] + 1;
        model_byte(g, b);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if ((rd_ptr[g] == wr_ptr[g]) && msg_q_size(g) == 0 && rt_q_size(g) == 0
                && !msg_valid[g]) break;
            n++;
            if (n >= 3000) break;
        end
        chk("drain_in_time", (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("drop_cnt_model", {24'd0, drop_cnt[g]}, m_drop[g]);
    endtask

    initial begin
        int b_rd, b_msg, b_rt, n;
        reset_n = 1'b0;
        msg_ready[0] = 1'b1;
        msg_ready[1] = 1'b1;
        model_reset();
        fork
            compare_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fifo_rd", {31'd0, f_rd[0]}, 32'd0);
        chk("rst_msg_valid", {31'd0, msg_valid[0]}, 32'd0);
        chk("rst_msg", pack_msg(msg_status[0], msg_d1[0], msg_d2[0], msg_len[0]), 32'd0);
        chk("rst_rt", {23'd0, rt_valid[0], rt_byte[0]}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt[0]}, 32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;

        // single note-on
        b_rd = rd_cnt[0]; b_msg = msg_cnt[0];
        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
        wait_idle(0);
        chk("t1_msg", last_msg[0], 32'h903C6402);
        chk("t1_pops", rd_cnt[0] - b_rd, 3);
        chk("t1_count", msg_cnt[0] - b_msg, 1);

        // running status
        b_msg = msg_cnt[0];
        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64); push(0, 8'h40); push(0, 8'h00);
        wait_idle(0);
        chk("t2_count", msg_cnt[0] - b_msg, 2);
        chk("t2_msg", last_msg[0], 32'h90400002);

        // real-time byte mid-message
        b_msg = msg_cnt[0]; b_rt = rt_cnt[0];
        push(0, 8'h90); push(0, 8'h3C); push(0, 8'hF8); push(0, 8'h64);
        wait_idle(0);
        chk("t3_rt_count", rt_cnt[0] - b_rt, 1);
        chk("t3_rt_byte", {24'd0, last_rt[0]}, 32'hF8);
        chk("t3_msg", last_msg[0], 32'h903C6402);
        chk("t3_count", msg_cnt[0] - b_msg, 1);

        // SysEx then orphan data byte
        b_msg = msg_cnt[0];
        push(0, 8'hF0); push(0, 8'h7E); push(0, 8'h01); push(0, 8'hF7); push(0, 8'h45);
        wait_idle(0);
        chk("t4_count", msg_cnt[0] - b_msg, 0);
        chk("t4_drop", {24'd0, drop_cnt[0]}, 32'd1);

        // active sensing suppressed, tune request, abandoned partial
        b_msg = msg_cnt[0]; b_rt = rt_cnt[0];
        push(0, 8'hFE); push(0, 8'hF6); push(0, 8'h90); push(0, 8'h11);
        push(0, 8'h80); push(0, 8'h22); push(0, 8'h33);
        wait_idle(0);
        chk("t5_rt_count", rt_cnt[0] - b_rt, 0);
        chk("t5_count", msg_cnt[0] - b_msg, 2);
        chk("t5_msg", last_msg[0], 32'h80223302);
        chk("t5_drop", {24'd0, drop_cnt[0]}, 32'd2);

        // back-pressure
        @(posedge clk); #2;
        msg_ready[0] = 1'b0;
        b_rd = rd_cnt[0];
        push(0, 8'hC5); push(0, 8'h07); push(0, 8'hB0);
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (msg_valid[0] || n >= 100) break;
            n++;
        end
        chk("t6_valid_in_time", (n >= 100) ? 32'd1 : 32'd0, 32'd0);
        b_msg = rd_cnt[0];
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_pops_held", rd_cnt[0] - b_msg, 0);
        chk("t6_still_valid", {31'd0, msg_valid[0]}, 32'd1);
        chk("t6_held_msg", pack_msg(msg_status[0], msg_d1[0], msg_d2[0], msg_len[0]), 32'hC5070001);
        @(posedge clk); #2;
        msg_ready[0] = 1'b1;
        wait_idle(0);
        chk("t6_pops", rd_cnt[0] - b_rd, 3);
        chk("t6_msg", last_msg[0], 32'hC5070001);

        // drop counter saturation
        for (int i = 0; i < 260; i++) push(0, 8'hF4);
        wait_idle(0);
        chk("t7_drop_sat", {24'd0, drop_cnt[0]}, 32'd255);

        // channel filter on instance 1
        b_msg = msg_cnt[1];
        push(1, 8'h91); push(1, 8'h40); push(1, 8'h40);
        push(1, 8'h92); push(1, 8'h40); push(1, 8'h40);
        wait_idle(1);
        chk("t8_count", msg_cnt[1] - b_msg, 1);
        chk("t8_msg", last_msg[1], 32'h92404002);
        push(1, 8'h92); push(1, 8'h40);
        wait_idle(1);
        chk("t8_status_before_rst", {24'd0, msg_status[1]}, 32'h92);

        // asynchronous reset mid-message
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("t9_rst_status", {24'd0, msg_status[1]}, 32'd0);
        chk("t9_rst_msg", pack_msg(msg_status[1], msg_d1[1], msg_d2[1], msg_len[1]), 32'd0);
        chk("t9_rst_drop0", {24'd0, drop_cnt[0]}, 32'd0);
        chk("t9_rst_valid", {31'd0, msg_valid[1]}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        push(1, 8'h40);
        wait_idle(1);
        chk("t9_orphan_drop", {24'd0, drop_cnt[1]}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
